seat_expiry_scanner: RTL

- Downstream companion of the seat memory.
- On every minute change of the system time, it walks all seats and reads each seat's state and limit time.
- For each occupied or away seat whose limit has passed, it issues a release write (state to EMPTY).
- It sits beside the host write path. Host writes always win; the scanner stalls until the write port is free.

---
 rtl/seating_pkg.sv | 34 +++
 rtl/time_elapsed_mod.sv | 30 +++
 rtl/seat_expiry_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seating_pkg.sv
// Shared seating definitions: seat state encoding, write field selects,
// time-of-day constants and the scanner FSM state type.
package seating_pkg;

    localparam int NUM_SEATS = 32;
    localparam int SEAT_W    = 5;
    localparam int TIME_W    = 11;
    localparam int DAY_MIN   = 1440;
    localparam int HALF_DAY  = 720;
    localparam int READ_LAT  = 1;
    localparam int CNT_W     = SEAT_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_OCCUPIED = 2'b01,
        ST_AWAY     = 2'b10,
        ST_BANNED   = 2'b11
    } seat_state_t;

    // Field select on the seat memory write port.
    localparam logic [1:0] WS_NONE  = 2'b00;
    localparam logic [1:0] WS_STATE = 2'b01;
    localparam logic [1:0] WS_LIMIT = 2'b10;
    localparam logic [1:0] WS_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EVAL  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/time_elapsed_mod.sv
// Wrap-safe minutes elapsed from limit_i to now_i on a circular day,
// computed one bit wider so the day offset is never truncated.
module time_elapsed_mod
    import seating_pkg::*;
#(
    parameter int TW      = TIME_W,
    parameter int DAY_LEN = DAY_MIN
) (
    input  logic [TW-1:0] now_i,
    input  logic [TW-1:0] limit_i,
    output logic [TW-1:0] elapsed_o
);

    localparam int SUM_W = TW + 1;
    localparam logic [SUM_W-1:0] DAY = SUM_W'(DAY_LEN);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] wrapped;

    always_comb begin
        sum     = {1'b0, now_i} + DAY - {1'b0, limit_i};
        wrapped = sum - DAY;
        if (sum >= DAY) begin
            elapsed_o = wrapped[TW-1:0];
        end else begin
            elapsed_o = sum[TW-1:0];
        end
    end

endmodule

// File: rtl/seat_expiry_scanner.sv
// Walks every seat on each minute change (or forced request) and releases
// occupied/away seats whose limit minute has passed; yields to host writes.
module seat_expiry_scanner
    import seating_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_in,
    input  logic              scan_req,
    input  logic              host_busy,
    output logic [SEAT_W-1:0] rd_seat,
    input  logic [1:0]        rd_state,
    input  logic [TIME_W-1:0] rd_limit,
    output logic              write,
    output logic [SEAT_W-1:0] wr_seat,
    output logic [1:0]        wr_state,
    output logic [1:0]        wr_set,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  expired_cnt
);

    scan_state_t       state_q, state_d;
    logic [SEAT_W-1:0] seat_q, seat_d;
    logic [1:0]        lat_q, lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  exp_cnt_q, exp_cnt_d;
    logic [TIME_W-1:0] prev_time_q;
    logic [TIME_W-1:0] scan_time_q, scan_time_d;
    logic              first_q, first_d;
    logic              pending_q, pending_d;

    logic              trigger;
    logic [TIME_W-1:0] eval_time;
    logic [TIME_W-1:0] elapsed;
    logic              live_seat;
    logic              expired;

    assign trigger   = (time_in != prev_time_q) || scan_req;
    // The first seat of a scan sees the minute live; later seats reuse it.
    assign eval_time = first_q ? time_in : scan_time_q;
    assign live_seat = (rd_state == ST_OCCUPIED) || (rd_state == ST_AWAY);
    assign expired   = live_seat && (elapsed < TIME_W'(HALF_DAY));

    time_elapsed_mod #(
        .TW      (TIME_W),
        .DAY_LEN (DAY_MIN)
    ) u_elapsed (
        .now_i     (eval_time),
        .limit_i   (rd_limit),
        .elapsed_o (elapsed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seat_q      <= '0;
            lat_q       <= '0;
            cnt_q       <= '0;
            exp_cnt_q   <= '0;
            prev_time_q <= '0;
            scan_time_q <= '0;
            first_q     <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seat_q      <= seat_d;
            lat_q       <= lat_d;
            cnt_q       <= cnt_d;
            exp_cnt_q   <= exp_cnt_d;
            prev_time_q <= time_in;
            scan_time_q <= scan_time_d;
            first_q     <= first_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seat_d      = seat_q;
        lat_d       = lat_q;
        cnt_d       = cnt_q;
        exp_cnt_d   = exp_cnt_q;
        scan_time_d = scan_time_q;
        first_d     = first_q;
        pending_d   = pending_q;
        write       = 1'b0;
        done        = 1'b0;

        // Any number of triggers during a scan collapse into one rescan.
        if (trigger && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = S_READ;
                    seat_d    = '0;
                    lat_d     = '0;
                    cnt_d     = '0;
                    first_d   = 1'b1;
                    pending_d = 1'b0;
                end
            end
            S_READ: begin
                if (lat_q == 2'(READ_LAT - 1)) begin
                    state_d = S_EVAL;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EVAL: begin
                if (first_q) begin
                    scan_time_d = time_in;
                    first_d     = 1'b0;
                end
                state_d = expired ? S_WRITE : S_NEXT;
            end
            S_WRITE: begin
                if (!host_busy) begin
                    write   = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (seat_q == SEAT_W'(NUM_SEATS - 1)) begin
                    done      = 1'b1;
                    exp_cnt_d = cnt_q;
                    state_d   = S_IDLE;
                end else begin
                    seat_d  = seat_q + SEAT_W'(1);
                    lat_d   = '0;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_seat     = seat_q;
    assign wr_seat     = seat_q;
    assign wr_state    = ST_EMPTY;
    assign wr_set      = write ? WS_STATE : WS_NONE;
    assign busy        = (state_q != S_IDLE);
    assign expired_cnt = exp_cnt_q;

endmodule
